// File: rtl/piece_ctrl.sv
// Falling-piece position controller: spawn, horizontal/vertical stepping, grounding and lock.
// Optional feature: define SOFT_DROP_EN to let btn_down turn horizontal ticks into vertical steps.
module piece_ctrl #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20,
  parameter int SPAWN_X    = 4,
  parameter int LOCK_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vertical_flag,
  input  logic       horizontal_flag,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       spawn,
  input  logic       collide_left,
  input  logic       collide_right,
  input  logic       collide_below,
  output logic [3:0] piece_x,
  output logic [4:0] piece_y,
  output logic       active,
  output logic       lock
);

  localparam int         CW      = (LOCK_TICKS < 2) ? 1 : $clog2(LOCK_TICKS + 1);
  localparam logic [3:0] X_MAX   = 4'(BOARD_W - 1);
  localparam logic [4:0] Y_MAX   = 5'(BOARD_H - 1);
  localparam logic [3:0] X_SPAWN = 4'(SPAWN_X);

  typedef enum logic [1:0] {IDLE, FALL, GROUNDED, LOCK} state_t;

  state_t        state;
  logic          pending;
  logic [CW-1:0] lock_cnt;

  logic          in_play;
  logic          step_left;
  logic          step_right;
  logic          drop_req;
  logic          v_req;
  logic          defer_v;
  logic          apply_v;
  logic          can_down;
  logic [CW-1:0] cnt_next;
  logic          lock_due;

`ifdef SOFT_DROP_EN
  assign drop_req = horizontal_flag & btn_down;
`else
  logic unused_btn_down;
  assign unused_btn_down = btn_down;
  assign drop_req        = 1'b0;
`endif

  always_comb begin
    in_play    = (state == FALL) || (state == GROUNDED);
    step_left  = in_play & horizontal_flag & btn_left & ~btn_right &
                 (piece_x != 4'd0) & ~collide_left;
    step_right = in_play & horizontal_flag & btn_right & ~btn_left &
                 (piece_x < X_MAX) & ~collide_right;
    // Any vertical request (fresh or carried over) yields to a horizontal tick
    // and is replayed the following cycle, so requests merge rather than queue.
    v_req      = in_play & (vertical_flag | drop_req | pending);
    defer_v    = v_req & horizontal_flag;
    apply_v    = v_req & ~horizontal_flag;
    can_down   = (piece_y < Y_MAX) & ~collide_below;
    cnt_next   = lock_cnt + 1'b1;
    lock_due   = int'(cnt_next) >= LOCK_TICKS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      piece_x  <= X_SPAWN;
      piece_y  <= 5'd0;
      active   <= 1'b0;
      lock     <= 1'b0;
      lock_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      lock <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn) begin
            state    <= FALL;
            piece_x  <= X_SPAWN;
            piece_y  <= 5'd0;
            active   <= 1'b1;
            lock_cnt <= '0;
            pending  <= 1'b0;
          end
        end
        FALL, GROUNDED: begin
          if (step_left)
            piece_x <= piece_x - 4'd1;
          else if (step_right)
            piece_x <= piece_x + 4'd1;
          pending <= defer_v;
          if (apply_v) begin
            if (can_down) begin
              piece_y  <= piece_y + 5'd1;
              state    <= FALL;
              lock_cnt <= '0;
            end else if (state == FALL) begin
              state    <= GROUNDED;
              lock_cnt <= '0;
            end else if (lock_due) begin
              state    <= LOCK;
              lock     <= 1'b1;
              active   <= 1'b0;
              pending  <= 1'b0;
              lock_cnt <= cnt_next;
            end else begin
              lock_cnt <= cnt_next;
            end
          end
        end
        LOCK: begin
          state    <= IDLE;
          lock_cnt <= '0;
          pending  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed self-checking bench for piece_ctrl; expected positions are hand-computed.
// Soft-drop expectations follow SOFT_DROP_EN when it is defined for the build.
module tb_piece_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vertical_flag = 1'b0;
  logic       horizontal_flag = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_down = 1'b0;
  logic       spawn = 1'b0;
  logic       collide_left = 1'b0;
  logic       collide_right = 1'b0;
  logic       collide_below = 1'b0;
  logic [3:0] piece_x;
  logic [4:0] piece_y;
  logic       active;
  logic       lock;

  int checks = 0;
  int failures = 0;
  int lock_pulses = 0;

  piece_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .vertical_flag   (vertical_flag),
    .horizontal_flag (horizontal_flag),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_down        (btn_down),
    .spawn           (spawn),
    .collide_left    (collide_left),
    .collide_right   (collide_right),
    .collide_below   (collide_below),
    .piece_x         (piece_x),
    .piece_y         (piece_y),
    .active          (active),
    .lock            (lock)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lock === 1'b1) lock_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vpulse();
    vertical_flag = 1'b1;
    tick();
    vertical_flag = 1'b0;
  endtask

  task automatic hpulse();
    horizontal_flag = 1'b1;
    tick();
    horizontal_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic spawn_piece();
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({piece_x, piece_y, active, lock} !== {4'd4, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got x=%0d y=%0d act=%b lock=%b, want x=4 y=0 act=0 lock=0", piece_x, piece_y, active, lock);
    end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({piece_x, piece_y, active, lock} !== {4'd4, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL wait_for_spawn: got x=%0d y=%0d act=%b lock=%b, want x=4 y=0 act=0 lock=0", piece_x, piece_y, active, lock);
    end
    $display("test_reset done");
  endtask

  task automatic test_spawn_fall_lock();
    int lp0;
    spawn_piece();
    checks++;
    if ({piece_x, piece_y, active, lock} !== {4'd4, 5'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL spawn_pos: got x=%0d y=%0d act=%b lock=%b, want x=4 y=0 act=1 lock=0", piece_x, piece_y, active, lock);
    end
    vpulse();
    spawn_piece();
    checks++;
    if ({piece_x, piece_y} !== {4'd4, 5'd1}) begin
      failures++;
      $display("FAIL spawn_ignored: got x=%0d y=%0d, want x=4 y=1", piece_x, piece_y);
    end
    repeat (18) vpulse();
    checks++;
    if ({piece_y, active} !== {5'd19, 1'b1}) begin
      failures++;
      $display("FAIL fall_to_bottom: got y=%0d act=%b, want y=19 act=1", piece_y, active);
    end
    lp0 = lock_pulses;
    vpulse();
    checks++;
    if ({piece_x, piece_y, active, lock} !== {4'd4, 5'd19, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL grounded_entry: got x=%0d y=%0d act=%b lock=%b, want x=4 y=19 act=1 lock=0", piece_x, piece_y, active, lock);
    end
    vpulse();
    checks++;
    if ({active, lock} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL grounded_tick1: got act=%b lock=%b, want act=1 lock=0", active, lock);
    end
    vpulse();
    checks++;
    if ({piece_x, piece_y, active, lock} !== {4'd4, 5'd19, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL lock_pulse: got x=%0d y=%0d act=%b lock=%b, want x=4 y=19 act=0 lock=1", piece_x, piece_y, active, lock);
    end
    tick();
    checks++;
    if ({active, lock} !== {1'b0, 1'b0}) begin
      failures++;
      $display("FAIL lock_one_cycle: got act=%b lock=%b, want act=0 lock=0", active, lock);
    end
    repeat (2) vpulse();
    checks++;
    if ({piece_x, piece_y, active, lock_pulses} !== {4'd4, 5'd19, 1'b0, lp0 + 1}) begin
      failures++;
      $display("FAIL idle_hold: got x=%0d y=%0d act=%b pulses=%0d, want x=4 y=19 act=0 pulses=%0d", piece_x, piece_y, active, lock_pulses - lp0, 1);
    end
    $display("test_spawn_fall_lock done");
  endtask

  task automatic test_walls();
    do_reset();
    spawn_piece();
    btn_left = 1'b1;
    repeat (4) hpulse();
    checks++;
    if (piece_x !== 4'd0) begin
      failures++;
      $display("FAIL walk_left: got x=%0d, want x=0", piece_x);
    end
    repeat (3) hpulse();
    checks++;
    if (piece_x !== 4'd0) begin
      failures++;
      $display("FAIL left_wall: got x=%0d, want x=0", piece_x);
    end
    btn_right = 1'b1;
    hpulse();
    checks++;
    if (piece_x !== 4'd0) begin
      failures++;
      $display("FAIL both_buttons: got x=%0d, want x=0", piece_x);
    end
    btn_left = 1'b0;
    hpulse();
    checks++;
    if (piece_x !== 4'd1) begin
      failures++;
      $display("FAIL step_right: got x=%0d, want x=1", piece_x);
    end
    collide_right = 1'b1;
    hpulse();
    collide_right = 1'b0;
    btn_right = 1'b0;
    btn_left = 1'b1;
    collide_left = 1'b1;
    hpulse();
    collide_left = 1'b0;
    btn_left = 1'b0;
    checks++;
    if (piece_x !== 4'd1) begin
      failures++;
      $display("FAIL collide_sides: got x=%0d, want x=1", piece_x);
    end
    btn_right = 1'b1;
    repeat (10) hpulse();
    btn_right = 1'b0;
    checks++;
    if ({piece_x, piece_y} !== {4'd9, 5'd0}) begin
      failures++;
      $display("FAIL right_wall: got x=%0d y=%0d, want x=9 y=0", piece_x, piece_y);
    end
    $display("test_walls done");
  endtask

  task automatic test_coincide();
    do_reset();
    spawn_piece();
    repeat (5) vpulse();
    btn_right = 1'b1;
    vertical_flag = 1'b1;
    horizontal_flag = 1'b1;
    tick();
    vertical_flag = 1'b0;
    horizontal_flag = 1'b0;
    btn_right = 1'b0;
    checks++;
    if ({piece_x, piece_y} !== {4'd5, 5'd5}) begin
      failures++;
      $display("FAIL coincide_h_first: got x=%0d y=%0d, want x=5 y=5", piece_x, piece_y);
    end
    tick();
    checks++;
    if ({piece_x, piece_y} !== {4'd5, 5'd6}) begin
      failures++;
      $display("FAIL coincide_v_next: got x=%0d y=%0d, want x=5 y=6", piece_x, piece_y);
    end
    vertical_flag = 1'b1;
    horizontal_flag = 1'b1;
    tick();
    horizontal_flag = 1'b0;
    tick();
    vertical_flag = 1'b0;
    tick();
    checks++;
    if (piece_y !== 5'd7) begin
      failures++;
      $display("FAIL pending_merge: got y=%0d, want y=7", piece_y);
    end
    vertical_flag = 1'b1;
    horizontal_flag = 1'b1;
    tick();
    vertical_flag = 1'b0;
    horizontal_flag = 1'b0;
    collide_below = 1'b1;
    tick();
    collide_below = 1'b0;
    checks++;
    if ({piece_y, active} !== {5'd7, 1'b1}) begin
      failures++;
      $display("FAIL pending_blocked: got y=%0d act=%b, want y=7 act=1", piece_y, active);
    end
    $display("test_coincide done");
  endtask

  task automatic test_grounded_recover();
    int lp0;
    lp0 = lock_pulses;
    vpulse();
    checks++;
    if (piece_y !== 5'd8) begin
      failures++;
      $display("FAIL unground_step: got y=%0d, want y=8", piece_y);
    end
    collide_below = 1'b1;
    vpulse();
    vpulse();
    collide_below = 1'b0;
    vpulse();
    checks++;
    if ({piece_y, active, lock_pulses} !== {5'd9, 1'b1, lp0}) begin
      failures++;
      $display("FAIL grounded_recover: got y=%0d act=%b pulses=%0d, want y=9 act=1 pulses=0", piece_y, active, lock_pulses - lp0);
    end
    $display("test_grounded_recover done");
  endtask

  task automatic test_reset_mid();
    int lp0;
    do_reset();
    spawn_piece();
    btn_right = 1'b1;
    repeat (3) hpulse();
    btn_right = 1'b0;
    repeat (12) vpulse();
    collide_below = 1'b1;
    vpulse();
    vpulse();
    checks++;
    if ({piece_x, piece_y, active, lock} !== {4'd7, 5'd12, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL grounded_7_12: got x=%0d y=%0d act=%b lock=%b, want x=7 y=12 act=1 lock=0", piece_x, piece_y, active, lock);
    end
    lp0 = lock_pulses;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({piece_x, piece_y, active, lock} !== {4'd4, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got x=%0d y=%0d act=%b lock=%b, want x=4 y=0 act=0 lock=0", piece_x, piece_y, active, lock);
    end
    tick();
    rst = 1'b1;
    tick();
    repeat (3) vpulse();
    collide_below = 1'b0;
    checks++;
    if ({piece_x, piece_y, active, lock_pulses} !== {4'd4, 5'd0, 1'b0, lp0}) begin
      failures++;
      $display("FAIL abandon_piece: got x=%0d y=%0d act=%b pulses=%0d, want x=4 y=0 act=0 pulses=0", piece_x, piece_y, active, lock_pulses - lp0);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_soft_drop();
    logic [4:0] exp_y;
`ifdef SOFT_DROP_EN
    exp_y = 5'd1;
`else
    exp_y = 5'd0;
`endif
    spawn_piece();
    btn_down = 1'b1;
    hpulse();
    checks++;
    if (piece_y !== 5'd0) begin
      failures++;
      $display("FAIL soft_drop_defer: got y=%0d, want y=0", piece_y);
    end
    btn_down = 1'b0;
    tick();
    checks++;
    if ({piece_x, piece_y} !== {4'd4, exp_y}) begin
      failures++;
      $display("FAIL soft_drop_step: got x=%0d y=%0d, want x=4 y=%0d", piece_x, piece_y, exp_y);
    end
    $display("test_soft_drop done");
  endtask

  initial begin
    test_reset();
    test_spawn_fall_lock();
    test_walls();
    test_coincide();
    test_grounded_recover();
    test_reset_mid();
    test_soft_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piece_ctrl.md
PIECE_CTRL -- requirements
Module: piece_ctrl

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board width in columns.
REQ-002 SHALL have parameter BOARD_H, default 20, board height in rows.
REQ-003 SHALL have parameter SPAWN_X, default 4, spawn column.
REQ-004 SHALL have parameter LOCK_TICKS, default 2, vertical ticks spent grounded before lock.
REQ-005 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: vertical_flag  in  1  one-cycle gravity tick from tick_gen.
REQ-008 SHALL have port: horizontal_flag  in  1  one-cycle input-sample tick from tick_gen.
REQ-009 SHALL have port: btn_left, btn_right, btn_down  in  1 each  level-sensitive, pre-debounced buttons.
REQ-010 SHALL have port: spawn  in  1  request a new piece.
REQ-011 SHALL have port: collide_left, collide_right, collide_below  in  1 each  board occupancy at the current position.
REQ-012 SHALL have port: piece_x  out  4  column; piece_y  out  5  row, 0 = top.
REQ-013 SHALL have port: active  out  1  high in FALL or GROUNDED.
REQ-014 SHALL have port: lock  out  1  one-cycle pulse when the piece is committed.

Function
REQ-015 SHALL implement states IDLE, FALL, GROUNDED, LOCK.
REQ-016 IDLE + spawn: next cycle piece_x=SPAWN_X, piece_y=0, state FALL; spawn in any other state is ignored.
REQ-017 Horizontal step: on horizontal_flag in FALL/GROUNDED, left-only with piece_x>0 and !collide_left gives piece_x-1; right-only with piece_x<BOARD_W-1 and !collide_right gives piece_x+1; both or neither pressed gives no move.
REQ-018 Vertical step: on vertical_flag in FALL, piece_y<BOARD_H-1 and !collide_below gives piece_y+1; otherwise state GROUNDED with lock_cnt=0.
REQ-019 vertical_flag and horizontal_flag in the same cycle: the horizontal step applies in that cycle; the vertical step is held in a pending bit and applied in the next cycle using that cycle's collide_below.
REQ-020 A pending vertical step SHALL NOT be lost: a new vertical_flag arriving while a step is pending merges into it.
REQ-021 GROUNDED: on each vertical_flag, if collide_below is low and piece_y<BOARD_H-1, return to FALL and apply the step; otherwise lock_cnt+1.
REQ-022 When lock_cnt reaches LOCK_TICKS, the state goes to LOCK.
REQ-023 LOCK: lock=1 for exactly one cycle; piece_x and piece_y hold; the next state is IDLE.
REQ-024 piece_x and piece_y SHALL hold in IDLE at their last values.
REQ-025 piece_x and piece_y SHALL never leave 0..BOARD_W-1 and 0..BOARD_H-1.
REQ-026 Outputs SHALL be registered; a position change is visible the cycle after the qualifying flag.

Reset
REQ-027 rst low SHALL immediately force: state IDLE, piece_x=SPAWN_X, piece_y=0, active=0, lock=0, lock_cnt=0, pending=0.
REQ-028 Reset mid-fall or mid-lock SHALL abandon the piece with no lock pulse.
REQ-029 After rst rises, the block SHALL wait for spawn.

Configuration
REQ-030 Macro SOFT_DROP_EN defined: in FALL or GROUNDED, horizontal_flag with btn_down high also requests a vertical step, under the same rules as vertical_flag, including REQ-019.
REQ-031 Macro SOFT_DROP_EN undefined: btn_down is present but ignored.

Verification
REQ-032 Reset, spawn pulse -> piece_x=4, piece_y=0, active=1 next cycle.
REQ-033 Empty board, 19 vertical_flags -> piece_y=19, then GROUNDED; 2 more flags -> single lock pulse, active=0.
REQ-034 piece_x=0, btn_left held, 3 horizontal_flags -> piece_x stays 0; btn_left and btn_right together -> no move.
REQ-035 vertical_flag and horizontal_flag coincide with btn_right at (4,5) -> (5,5) that cycle, then (5,6) the next cycle.
REQ-036 GROUNDED with collide_below=1, clear collide_below before the 2nd tick -> returns to FALL, piece_y+1, no lock.
REQ-037 rst low during GROUNDED at (7,12) -> IDLE, (4,0), no lock; with SOFT_DROP_EN, btn_down plus horizontal_flag -> piece_y+1.
